// File: rtl/avalon_sdr_writer.sv
// Avalon-MM write master: streams a latched buffer of 32-bit elements to a
// 16-bit SDRAM slave port, low halfword first, one halfword per accepted transfer.
module avalon_sdr_writer #(
   parameter int MAX_ELEMS = 64,
   parameter int BUF_W     = 32 * MAX_ELEMS
) (
   input  logic              clkin,
   input  logic              reset,
   input  logic              sdr_writestart,
   input  logic [31:0]       sdr_baseaddr,
   input  logic [29:0]       sdr_nelems,
   input  logic [BUF_W-1:0]  sdr_writedata,
   output logic              sdr_busy,
   output logic              sdr_writeend,
   output logic [31:0]       avm_m0_address,
   output logic              avm_m0_write,
   output logic [15:0]       avm_m0_writedata,
   output logic [1:0]        avm_m0_byteenable,
   input  logic              avm_m0_waitrequest
);

   localparam int IW = (2 * MAX_ELEMS > 1) ? $clog2(2 * MAX_ELEMS) : 1;
   localparam logic [29:0] LP_MAX = 30'(MAX_ELEMS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_DONE
   } state_t;

   state_t             r_state, w_state;
   logic [30:0]        r_index, w_index;
   logic [30:0]        r_total, w_total;
   logic [BUF_W-1:0]   r_buf, w_buf;
   logic [31:0]        r_addr, w_addr;
   logic [15:0]        r_wdata, w_wdata;
   logic               r_write, w_write;
   logic [1:0]         r_be, w_be;
   logic               r_busy, w_busy;
   logic               r_wend, w_wend;

   logic [29:0]        w_clamp;
   logic [30:0]        w_req_total;
   logic [30:0]        w_nidx;
   logic [IW-1:0]      w_sel;
   logic [15:0]        w_half;

   assign w_clamp     = (sdr_nelems > LP_MAX) ? LP_MAX : sdr_nelems;
   assign w_req_total = {w_clamp, 1'b0};
   assign w_nidx      = r_index + 31'd1;
   assign w_sel       = w_nidx[IW-1:0];
   assign w_half      = r_buf[{w_sel, 4'b0000} +: 16];

   always_comb begin
      w_state = r_state;
      w_index = r_index;
      w_total = r_total;
      w_buf   = r_buf;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_write = r_write;
      w_be    = r_be;
      w_busy  = r_busy;
      w_wend  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (sdr_writestart) begin
               w_buf   = sdr_writedata;
               w_total = w_req_total;
               w_index = 31'd0;
               if (w_req_total != 31'd0) begin
                  w_state = S_WRITE;
                  w_addr  = sdr_baseaddr;
                  w_wdata = sdr_writedata[15:0];
                  w_write = 1'b1;
                  w_be    = 2'b11;
                  w_busy  = 1'b1;
               end else begin
                  w_state = S_DONE;
                  w_wend  = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (r_write && !avm_m0_waitrequest) begin
               if (w_nidx < r_total) begin
                  w_index = w_nidx;
                  w_addr  = r_addr + 32'd2;
                  w_wdata = w_half;
               end else begin
                  w_state = S_DONE;
                  w_addr  = 32'd0;
                  w_wdata = 16'd0;
                  w_write = 1'b0;
                  w_be    = 2'b00;
                  w_busy  = 1'b0;
                  w_wend  = 1'b1;
               end
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // Async reset also drops an in-flight write on the same instant.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_index <= '0;
         r_total <= '0;
         r_buf   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
         r_be    <= 2'b00;
         r_busy  <= 1'b0;
         r_wend  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_index <= w_index;
         r_total <= w_total;
         r_buf   <= w_buf;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
         r_write <= w_write;
         r_be    <= w_be;
         r_busy  <= w_busy;
         r_wend  <= w_wend;
      end
   end

   assign sdr_busy          = r_busy;
   assign sdr_writeend      = r_wend;
   assign avm_m0_address    = r_addr;
   assign avm_m0_write      = r_write;
   assign avm_m0_writedata  = r_wdata;
   assign avm_m0_byteenable = r_be;

endmodule

// File: tb/tb_avalon_sdr_writer.sv
// Directed bench for avalon_sdr_writer: bursts, stalls, clamping, restart,
// mid-burst reset and address wrap, checked with immediate assertions.
module tb_avalon_sdr_writer;

   localparam int MAX_ELEMS = 64;
   localparam int BUF_W     = 32 * MAX_ELEMS;

   logic              clkin = 1'b0;
   logic              reset = 1'b1;
   logic              sdr_writestart = 1'b0;
   logic [31:0]       sdr_baseaddr = '0;
   logic [29:0]       sdr_nelems = '0;
   logic [BUF_W-1:0]  sdr_writedata = '0;
   logic              sdr_busy;
   logic              sdr_writeend;
   logic [31:0]       avm_m0_address;
   logic              avm_m0_write;
   logic [15:0]       avm_m0_writedata;
   logic [1:0]        avm_m0_byteenable;
   logic              avm_m0_waitrequest = 1'b0;

   avalon_sdr_writer #(.MAX_ELEMS(MAX_ELEMS)) dut (
      .clkin              (clkin),
      .reset              (reset),
      .sdr_writestart     (sdr_writestart),
      .sdr_baseaddr       (sdr_baseaddr),
      .sdr_nelems         (sdr_nelems),
      .sdr_writedata      (sdr_writedata),
      .sdr_busy           (sdr_busy),
      .sdr_writeend       (sdr_writeend),
      .avm_m0_address     (avm_m0_address),
      .avm_m0_write       (avm_m0_write),
      .avm_m0_writedata   (avm_m0_writedata),
      .avm_m0_byteenable  (avm_m0_byteenable),
      .avm_m0_waitrequest (avm_m0_waitrequest)
   );

   always #5 clkin = ~clkin;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] cap_addr [0:255];
   logic [15:0] cap_data [0:255];
   int acc, we_cyc, we_cnt, wr_seen, busy_seen, unstable, be_bad;
   logic busy1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic burst(input logic [31:0] base, input logic [29:0] n,
                        input int stall, input int restart_at,
                        input int budget);
      int sc;
      bit held;
      logic [31:0] ha;
      logic [15:0] hd;
      acc = 0; we_cyc = -1; we_cnt = 0; wr_seen = 0; busy_seen = 0;
      unstable = 0; be_bad = 0; busy1 = 1'b0;
      sc = 0; held = 0; ha = '0; hd = '0;
      @(negedge clkin);
      sdr_baseaddr = base;
      sdr_nelems = n;
      sdr_writestart = 1'b1;
      avm_m0_waitrequest = 1'b0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge clkin);
         if (cyc == restart_at) begin
            sdr_writestart = 1'b1;
            sdr_baseaddr = 32'h9000_0000;
            sdr_writedata = ~sdr_writedata;
         end else begin
            sdr_writestart = 1'b0;
         end
         if (cyc == 1) busy1 = sdr_busy;
         if (sdr_busy) busy_seen++;
         if (sdr_writeend) begin
            we_cnt++;
            if (we_cyc < 0) we_cyc = cyc;
         end
         if (avm_m0_write) begin
            wr_seen++;
            if (avm_m0_byteenable !== 2'b11) be_bad++;
            if (held && (avm_m0_address !== ha || avm_m0_writedata !== hd))
               unstable++;
            if (sc < stall) begin
               avm_m0_waitrequest = 1'b1;
               sc++;
               held = 1;
               ha = avm_m0_address;
               hd = avm_m0_writedata;
            end else begin
               avm_m0_waitrequest = 1'b0;
               if (acc < 256) begin
                  cap_addr[acc] = avm_m0_address;
                  cap_data[acc] = avm_m0_writedata;
               end
               acc++;
               sc = 0;
               held = 0;
            end
         end else begin
            avm_m0_waitrequest = 1'b0;
            held = 0;
         end
         if (we_cyc > 0 && cyc >= we_cyc + 1) break;
      end
      sdr_writestart = 1'b0;
      avm_m0_waitrequest = 1'b0;
   endtask

   task automatic load_t1();
      sdr_writedata = '0;
      sdr_writedata[31:0]  = 32'hDEADBEEF;
      sdr_writedata[63:32] = 32'hCAFEBABE;
   endtask

   initial begin
      int wbad, ebad;
      // reset state
      #12;
      chk("rst_write", {31'd0, avm_m0_write}, 32'd0);
      chk("rst_addr", avm_m0_address, 32'd0);
      chk("rst_data", {16'd0, avm_m0_writedata}, 32'd0);
      chk("rst_be", {30'd0, avm_m0_byteenable}, 32'd0);
      chk("rst_busy", {31'd0, sdr_busy}, 32'd0);
      chk("rst_wend", {31'd0, sdr_writeend}, 32'd0);
      @(negedge clkin);
      reset = 1'b0;

      // 1: basic two-element burst
      load_t1();
      burst(32'h100, 30'd2, 0, 0, 20);
      chk("t1_acc", acc, 4);
      chk("t1_a0", cap_addr[0], 32'h100);
      chk("t1_d0", {16'd0, cap_data[0]}, 32'hBEEF);
      chk("t1_a1", cap_addr[1], 32'h102);
      chk("t1_d1", {16'd0, cap_data[1]}, 32'hDEAD);
      chk("t1_a2", cap_addr[2], 32'h104);
      chk("t1_d2", {16'd0, cap_data[2]}, 32'hBABE);
      chk("t1_a3", cap_addr[3], 32'h106);
      chk("t1_d3", {16'd0, cap_data[3]}, 32'hCAFE);
      chk("t1_we_cyc", we_cyc, 5);
      chk("t1_we_cnt", we_cnt, 1);
      chk("t1_busy1", {31'd0, busy1}, 32'd1);
      chk("t1_busy_cnt", busy_seen, 4);
      chk("t1_be", be_bad, 0);

      // 2: three stall cycles before each accept
      burst(32'h100, 30'd2, 3, 0, 40);
      chk("t2_acc", acc, 4);
      chk("t2_stable", unstable, 0);
      chk("t2_we_cnt", we_cnt, 1);
      chk("t2_we_cyc", we_cyc, 17);
      chk("t2_d3", {16'd0, cap_data[3]}, 32'hCAFE);
      chk("t2_a3", cap_addr[3], 32'h106);

      // 3: zero elements
      burst(32'h200, 30'd0, 0, 0, 10);
      chk("t3_wr", wr_seen, 0);
      chk("t3_we_cyc", we_cyc, 1);
      chk("t3_busy", busy_seen, 0);
      chk("t3_we_cnt", we_cnt, 1);

      // 4: clamp to MAX_ELEMS
      for (int i = 0; i < MAX_ELEMS; i++)
         sdr_writedata[32*i +: 32] = {16'(2*i+1), 16'(2*i)};
      burst(32'h2000, 30'(MAX_ELEMS + 5), 0, 0, 200);
      chk("t4_acc", acc, 2 * MAX_ELEMS);
      chk("t4_last_a", cap_addr[2*MAX_ELEMS-1], 32'h2000 + 4*MAX_ELEMS - 2);
      chk("t4_last_d", {16'd0, cap_data[2*MAX_ELEMS-1]}, 2*MAX_ELEMS - 1);
      chk("t4_mid_d", {16'd0, cap_data[MAX_ELEMS]}, MAX_ELEMS);
      chk("t4_we_cyc", we_cyc, 2 * MAX_ELEMS + 1);

      // 5: restart pulse mid-burst ignored
      load_t1();
      burst(32'h300, 30'd2, 0, 2, 20);
      chk("t5_acc", acc, 4);
      chk("t5_a0", cap_addr[0], 32'h300);
      chk("t5_a3", cap_addr[3], 32'h306);
      chk("t5_d2", {16'd0, cap_data[2]}, 32'hBABE);
      chk("t5_d3", {16'd0, cap_data[3]}, 32'hCAFE);
      chk("t5_we_cnt", we_cnt, 1);

      // 6: reset after second accept
      load_t1();
      @(negedge clkin);
      sdr_baseaddr = 32'h400;
      sdr_nelems = 30'd2;
      sdr_writestart = 1'b1;
      @(negedge clkin);
      sdr_writestart = 1'b0;
      @(negedge clkin);
      @(negedge clkin);
      chk("t6_pre_a", avm_m0_address, 32'h404);
      reset = 1'b1;
      #1;
      chk("t6_write", {31'd0, avm_m0_write}, 32'd0);
      chk("t6_addr", avm_m0_address, 32'd0);
      chk("t6_be", {30'd0, avm_m0_byteenable}, 32'd0);
      chk("t6_busy", {31'd0, sdr_busy}, 32'd0);
      @(negedge clkin);
      reset = 1'b0;
      wbad = 0;
      ebad = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clkin);
         if (sdr_writeend) ebad++;
         if (avm_m0_write) wbad++;
      end
      chk("t6_no_wend", ebad, 0);
      chk("t6_no_write", wbad, 0);
      burst(32'h500, 30'd2, 0, 0, 20);
      chk("t6_acc", acc, 4);
      chk("t6_a0", cap_addr[0], 32'h500);
      chk("t6_d0", {16'd0, cap_data[0]}, 32'hBEEF);

      // 7: address wrap
      burst(32'hFFFF_FFFE, 30'd1, 0, 0, 20);
      chk("t7_acc", acc, 2);
      chk("t7_a0", cap_addr[0], 32'hFFFF_FFFE);
      chk("t7_a1", cap_addr[1], 32'h0000_0000);
      chk("t7_d1", {16'd0, cap_data[1]}, 32'hDEAD);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
